// File: rtl/cbus_arb_pkg.sv
// ============================================================================
// Module   : cbus_arb_pkg
// Brief    : Shared types and helpers for the CBus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_arb_pkg;
  `include "common.svh"

  localparam int MAX_INPUTS = 8;

  typedef logic [$clog2(MAX_INPUTS)-1:0] grant_idx_t;

  function automatic grant_idx_t wrap_inc(input grant_idx_t idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + grant_idx_t'(1);
  endfunction
endpackage

`default_nettype wire

// File: rtl/cbus_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotating-priority picker; the lowest index at or
//            above start (with wrap) wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic          any,
  output logic [IW-1:0] winner
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  always_comb begin
    w_dbl  = {valid, valid};
    w_rot  = w_dbl[start +: N];
    any    = |valid;
    winner = '0;
    // Descending scan so the smallest rotated offset is assigned last.
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) winner = IW'((int'(start) + k) % N);
    end
  end

endmodule

`default_nettype wire

// File: rtl/common.svh
// Shared CBus request/response types and the MLEN/MSIZE encodings used by
// every cache-side block.
typedef logic [2:0] msize_t;
typedef logic [3:0] mlen_t;

localparam msize_t MSIZE1  = 3'd0;
localparam msize_t MSIZE2  = 3'd1;
localparam msize_t MSIZE4  = 3'd2;
localparam msize_t MSIZE8  = 3'd3;

// Burst length is encoded as beats minus one.
localparam mlen_t  MLEN1   = 4'd0;
localparam mlen_t  MLEN2   = 4'd1;
localparam mlen_t  MLEN4   = 4'd3;
localparam mlen_t  MLEN8   = 4'd7;
localparam mlen_t  MLEN16  = 4'd15;

typedef struct packed {
  logic        valid;
  logic        is_write;
  logic [31:0] addr;
  msize_t      size;
  mlen_t       len;
  logic [3:0]  strobe;
  logic [31:0] data;
} cbus_req_t;

typedef struct packed {
  logic        ready;
  logic        last;
  logic [31:0] data;
} cbus_resp_t;

// File: rtl/cbus_arbiter.sv
// ============================================================================
// Module   : cbus_arbiter
// Brief    : Burst-locking CBus arbiter between cache requesters. Define
//            CBUS_ARBITER_RR_EN for round-robin; otherwise fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cbus_arbiter
  import cbus_arb_pkg::*;
#(
  parameter  int NUM_INPUTS = 2,
  localparam int IDX_BITS   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  cbus_req_t           ireqs  [NUM_INPUTS],
  output cbus_resp_t          iresps [NUM_INPUTS],
  output cbus_req_t           oreq,
  input  cbus_resp_t          oresp,
  output logic                busy,
  output logic [IDX_BITS-1:0] grant_idx
);

  logic                  r_busy;
  logic [IDX_BITS-1:0]   r_index;
  logic [IDX_BITS-1:0]   w_prio;
  logic [NUM_INPUTS-1:0] w_valid;
  logic                  w_any;
  logic [IDX_BITS-1:0]   w_pick;
  logic                  w_release;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) w_valid[i] = ireqs[i].valid;
  end

  assign w_release = r_busy && oresp.ready && oresp.last;

  rr_pick #(
    .N  (NUM_INPUTS),
    .IW (IDX_BITS)
  ) u_pick (
    .valid  (w_valid),
    .start  (w_prio),
    .any    (w_any),
    .winner (w_pick)
  );

`ifdef CBUS_ARBITER_RR_EN
  logic [IDX_BITS-1:0] r_prio;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= '0;
    end else if (w_release) begin
      r_prio <= IDX_BITS'(wrap_inc(grant_idx_t'(r_index), NUM_INPUTS));
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = '0;
`endif

  // Release and arbitration are mutually exclusive, which leaves one idle
  // cycle between consecutive grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_index <= '0;
    end else if (r_busy) begin
      if (w_release) r_busy <= 1'b0;
    end else if (w_any) begin
      r_busy  <= 1'b1;
      r_index <= w_pick;
    end
  end

  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
      if (r_busy && (r_index == IDX_BITS'(i))) begin
        oreq      = ireqs[i];
        iresps[i] = oresp;
      end
    end
  end

  assign busy      = r_busy;
  assign grant_idx = r_index;

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
// ============================================================================
// Module   : tb_cbus_arbiter
// Brief    : Randomized scoreboard bench for cbus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cbus_arbiter;
  import cbus_arb_pkg::*;

  localparam int N         = 2;
  localparam int IB        = (N > 1) ? $clog2(N) : 1;
  localparam int IDLE_END  = 16;
  localparam int RUN_END   = 3000;
  localparam int RST_AFTER = 600;

  logic          clk = 1'b0;
  logic          reset;
  cbus_req_t     ireqs  [N];
  cbus_resp_t    iresps [N];
  cbus_req_t     oreq;
  cbus_resp_t    oresp;
  logic          busy;
  logic [IB-1:0] grant_idx;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        cyc;
    int        idx;
    cbus_req_t req;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ngrants = 0;

  // Abstract model: who owns the bus, how many beats remain, where the scan starts.
  bit m_busy = 1'b0, n_busy = 1'b0;
  int m_owner = 0, n_owner = 0;
  int m_prio = 0, n_prio = 0;
  int m_left = 0, n_left = 0;
  bit active [N];
  bit done_flag [N];
  bit rst_done = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [95:0] act, input logic [95:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  function automatic int pick(input bit [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic cbus_req_t new_req();
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.addr     = $urandom;
    r.size     = MSIZE4;
    case ($urandom_range(0, 2))
      0:       r.len = MLEN1;
      1:       r.len = MLEN2;
      default: r.len = MLEN4;
    endcase
    r.strobe   = 4'($urandom_range(0, 15));
    r.data     = $urandom;
    return r;
  endfunction

  // Driver and reference model
  initial begin
    bit [N-1:0] v;
    int w;
    reset = 1'b1;
    oresp = '0;
    for (int i = 0; i < N; i++) begin
      ireqs[i] = '0;
      active[i] = 1'b0;
      done_flag[i] = 1'b0;
    end
    while (cyc < RUN_END) begin
      @(posedge clk);
      cyc++;
      m_busy = n_busy; m_owner = n_owner; m_prio = n_prio; m_left = n_left;
      #1;
      for (int i = 0; i < N; i++) begin
        if (done_flag[i]) begin
          ireqs[i] = '0;
          active[i] = 1'b0;
          done_flag[i] = 1'b0;
        end else if (!active[i] && cyc >= IDLE_END && cyc < RUN_END - 60 &&
                     $urandom_range(0, 1) == 1) begin
          ireqs[i] = new_req();
          active[i] = 1'b1;
        end
      end

      reset = (cyc < 4);
      oresp.data  = $urandom;
      oresp.ready = 1'b0;
      oresp.last  = 1'b0;
      if (!rst_done && cyc > RST_AFTER && m_busy &&
          ireqs[m_owner].len == MLEN4 && m_left == 3) begin
        reset = 1'b1;
        rst_done = 1'b1;
        oresp.ready = 1'b1;
      end else if (m_busy && $urandom_range(0, 2) != 0) begin
        oresp.ready = 1'b1;
        oresp.last  = (m_left == 1);
      end

      if (reset) begin
        n_busy = 1'b0; n_owner = 0; n_prio = 0; n_left = 0;
        for (int i = 0; i < N; i++) if (active[i]) done_flag[i] = 1'b1;
      end else if (!m_busy) begin
        for (int i = 0; i < N; i++) v[i] = ireqs[i].valid;
        w = pick(v, m_prio);
        if (w >= 0) begin
          exp_q.push_back('{cyc: cyc + 1, idx: w, req: ireqs[w]});
          n_busy  = 1'b1;
          n_owner = w;
          n_left  = int'(ireqs[w].len) + 1;
        end
      end else if (oresp.ready) begin
        n_left = m_left - 1;
        if (oresp.last) begin
          n_busy = 1'b0;
`ifdef CBUS_ARBITER_RR_EN
          n_prio = (m_owner + 1) % N;
`else
          n_prio = 0;
`endif
          done_flag[m_owner] = 1'b1;
        end
      end
    end
    repeat (4) @(posedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", 96'(exp_q.size()), 96'(0));
    chk(rst_done, "reset_in_burst_reached", 96'(rst_done), 96'(1));
    chk(ngrants > 20, "grant_count", 96'(ngrants), 96'(21));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor
  initial begin
    logic prev_busy;
    exp_t e;
    cbus_req_t  er;
    cbus_resp_t ep;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc >= 2) begin
        chk(busy == m_busy, "busy", 96'(busy), 96'(m_busy));
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          chk(1'b0, "grant_missed", 96'(cyc), 96'(e.cyc));
        end
        if (busy && !prev_busy) begin
          ngrants++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "grant_unexpected", 96'(grant_idx), 96'(0));
          end else begin
            e = exp_q.pop_front();
            chk(e.cyc == cyc, "grant_cycle", 96'(cyc), 96'(e.cyc));
            chk(int'(grant_idx) == e.idx, "grant_idx", 96'(grant_idx), 96'(e.idx));
            chk(oreq == e.req, "grant_oreq", 96'(oreq), 96'(e.req));
          end
        end
        if (m_busy)
          chk(int'(grant_idx) == m_owner, "owner_idx", 96'(grant_idx), 96'(m_owner));
        er = m_busy ? ireqs[m_owner] : '0;
        chk(oreq == er, "oreq", 96'(oreq), 96'(er));
        for (int j = 0; j < N; j++) begin
          ep = (m_busy && j == m_owner) ? oresp : '0;
          chk(iresps[j] == ep, $sformatf("iresps%0d", j), 96'(iresps[j]), 96'(ep));
        end
        prev_busy = busy;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/cbus_arbiter.md
# cbus_arbiter

Arbitrates the single cache bus (CBus) between N cache-side requesters: ICache, DCache refill/writeback, and the DCache uncached path. Sits between the cache controllers and the AXI/CBus bridge. Grants one requester at a time and holds the grant for a whole burst, until the beat that carries `cresp.last`. It then rotates priority so no requester starves.

## Interface
Parameters:
- `NUM_INPUTS`, default 2: number of requesters (2..8).
- `IDX_BITS`, default `$clog2(NUM_INPUTS)`: grant index width (localparam).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS]`: requests from the caches. Index 0 is highest priority at reset.
- `iresps`  out  `cbus_resp_t [NUM_INPUTS]`: per-requester responses.
- `oreq`  out  `cbus_req_t`: request to the bus bridge.
- `oresp`  in  `cbus_resp_t`: response from the bus bridge.
- `busy`  out  1: a grant is held.
- `grant_idx`  out  `IDX_BITS`: index of the current or last grantee.

## Operation
- State: `busy` (1 bit), `index` (`IDX_BITS`), `prio` (`IDX_BITS`, round-robin start pointer).
- IDLE (`busy`=0):
  - Pick a winner among `ireqs[i].valid` by scanning from `prio` upward, with wrap-around.
  - If any requester is valid, latch the winner into `index` and set `busy`.
  - No request is forwarded during IDLE.
- BUSY (`busy`=1):
  - `oreq = ireqs[index]` with every field passed through unchanged (`addr`, `size`, `len`, `strobe`, `data`, `is_write`, `valid`).
  - `iresps[index] = oresp`.
  - Every other `iresps[j]` is all-zero.
- Release: on a cycle with `oresp.ready && oresp.last`:
  - `busy` goes to 0.
  - `prio` goes to `index+1`, wrapping modulo `NUM_INPUTS`.
- No arbitration in the release cycle. A new grant can start, at the earliest, in the cycle after release.
- The grantee must hold `valid` and its request fields stable until `last`; this is required of requesters. If the grantee drops `valid` mid-burst, the arbiter stays BUSY, forwards `oreq.valid`=0 and waits; it does not release early.
- Non-granted requesters see `ready`=0 and `last`=0 for as long as they wait.
- Single-beat uncached accesses (`len`=MLEN1) are treated exactly like bursts: release happens on their only beat.

## Timing
- Reset values:
  - `busy`=0, `index`=0, `prio`=0.
  - `oreq`='0, every `iresps`='0, `grant_idx`=0.
- Latency:
  - Request valid in cycle T with the arbiter IDLE: grant is registered at the edge ending T.
  - `oreq.valid`=1 in cycle T+1.
  - Total arbitration overhead is one cycle per transaction.
- Back-to-back: release in cycle R, next grant visible in R+2. Cycle R+1 is the arbitration cycle.
- `oresp` feeds through to `iresps[index]` combinationally, with zero added latency. `oreq` is combinational from `ireqs` and `index`.
- Simultaneous requests: the lowest index at or above `prio` (with wrap) wins.
- Reset during BUSY:
  - The arbiter returns to IDLE on the next edge and the downstream request is dropped.
  - The bridge is reset in the same cycle, so no orphaned beats are expected.
- `NUM_INPUTS`=1: always grants index 0; the one-cycle arbitration gap is kept.

## Configuration
- `CBUS_ARBITER_RR_EN`:
  - Defined: round-robin as described above; `prio` advances on every release.
  - Undefined: fixed priority. `prio` is held at 0, so index 0 always wins ties; the `prio` register is optimised away.
- Both modes keep burst locking and identical timing.

## Structure
- Shared package `cbus_arb_pkg`:
  - `MAX_INPUTS`=8.
  - Typedef `grant_idx_t`.
  - Helper function `wrap_inc(idx, n)`.
- `cbus_req_t`, `cbus_resp_t`, `MLEN*` and `MSIZE*` stay in `common.svh` and are not redefined.
- One sub-module, `rr_pick`: combinational rotating priority picker.
  - Inputs: valid vector and start pointer.
  - Outputs: `any` and winner index.
- The top level holds the registers, the mux and the response demux.

## Test plan
- Reset, then idle: all outputs zero, `busy`=0 for 10 cycles.
- Only `ireqs[1]`: MLEN4 read at 0x8000_0040.
  - Cycle 1: `oreq.valid`=1, addr 0x8000_0040.
  - Four `ready` beats with data 0xA0..0xA3 appear on `iresps[1]` only.
  - Release after the fourth beat (`last`).
- `ireqs[0]` and `ireqs[1]` both valid at once, from reset (RR enabled):
  - Grant 0 first, then grant 1 exactly two cycles after 0's `last`.
  - Repeat the pair; grant order is 0,1,0,1.
  - With `CBUS_ARBITER_RR_EN` undefined and both requests kept asserted: grant order is 0,0,0.
- `ireqs[1]` rises mid-burst of grantee 0: `iresps[1].ready` stays 0 throughout. Grant passes to 1 after 0's `last`.
- Uncached MLEN1 write, strobe 4'b0011, data 0x1234_5678, from requester 1:
  - Forwarded unchanged.
  - Released on its single `ready`+`last` beat.
- Assert `reset` during beat 2 of a 4-beat burst: next cycle `busy`=0, `oreq`='0 and `prio`=0.
